// File: rtl/adder_stim_sequencer.sv
// rtl/adder_stim_sequencer.sv - LFSR-driven stimulus sequencer and checker for the lab 4 adder top level
//
// Drives the SW / LoadA / LoadB / Run button interface of the adder, waits
// for the result, compares {CO,Sum} against an internal 17-bit A+B and keeps
// vector / error counts plus the operands of the first failing vector.
//
// Ports:
//   Clk       in   system clock
//   Reset     in   asynchronous active-low reset
//   Start     in   begins a run when sampled high in IDLE
//   Sum, CO   in   adder result and carry out
//   SW        out  operand presented to the adder
//   LoadA     out  active-low load strobe for register A (idle 1)
//   LoadB     out  active-low load strobe for register B (idle 1)
//   Run       out  active-low compute strobe (idle 1)
//   Busy      out  high while a run is in progress
//   Done      out  sticky completion flag, cleared by the next accepted Start
//   VecCount  out  vectors checked in the current/last run
//   ErrCount  out  mismatches, saturating at 255
//   FailA/B   out  operands of the first failing vector, 0 if none

module adder_stim_sequencer #(
  parameter int          NUM_VEC   = 16,
  parameter int          PULSE_LEN = 2,
  parameter int          WAIT_CYC  = 20,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Sum,
  input  logic        CO,
  output logic [15:0] SW,
  output logic        LoadA,
  output logic        LoadB,
  output logic        Run,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  VecCount,
  output logic [7:0]  ErrCount,
  output logic [15:0] FailA,
  output logic [15:0] FailB
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LDA   = 4'd1;
  localparam logic [3:0] S_GAPA  = 4'd2;
  localparam logic [3:0] S_LDB   = 4'd3;
  localparam logic [3:0] S_GAPB  = 4'd4;
  localparam logic [3:0] S_RUN   = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
  localparam logic [3:0] S_CHECK = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] PL_LAST  = 16'(PULSE_LEN - 1);
  localparam logic [15:0] WC_LAST  = 16'(WAIT_CYC - 1);
  localparam logic [7:0]  VEC_LAST = 8'(NUM_VEC);

  logic [3:0]  state;
  logic [15:0] cnt;
  logic [15:0] lfsr;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic [15:0] lfsr_next;
  logic [16:0] expected;
  logic        mismatch;
  logic [7:0]  vec_next;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign expected  = {1'b0, op_a} + {1'b0, op_b};
  assign mismatch  = ({CO, Sum} != expected);
  assign vec_next  = VecCount + 8'd1;

  // Outputs are updated on the edge that enters each state, so a strobe and
  // the SW value it qualifies always change together and stay registered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lfsr     <= SEED_EFF;
      op_a     <= '0;
      op_b     <= '0;
      SW       <= '0;
      LoadA    <= 1'b1;
      LoadB    <= 1'b1;
      Run      <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      VecCount <= '0;
      ErrCount <= '0;
      FailA    <= '0;
      FailB    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            VecCount <= '0;
            ErrCount <= '0;
            FailA    <= '0;
            FailB    <= '0;
            Done     <= 1'b0;
            Busy     <= 1'b1;
            op_a     <= lfsr;
            SW       <= lfsr;
            lfsr     <= lfsr_next;
            LoadA    <= 1'b0;
            cnt      <= '0;
            state    <= S_LDA;
          end
        end

        S_LDA: begin
          // B is drawn once, on the first cycle of the A pulse, so it is
          // ready well before it has to appear on SW.
          if (cnt == 16'd0) begin
            op_b <= lfsr;
            lfsr <= lfsr_next;
          end
          if (cnt == PL_LAST) begin
            LoadA <= 1'b1;
            cnt   <= '0;
            state <= S_GAPA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_GAPA: begin
          SW    <= op_b;
          LoadB <= 1'b0;
          cnt   <= '0;
          state <= S_LDB;
        end

        S_LDB: begin
          if (cnt == PL_LAST) begin
            LoadB <= 1'b1;
            cnt   <= '0;
            state <= S_GAPB;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_GAPB: begin
          Run   <= 1'b0;
          cnt   <= '0;
          state <= S_RUN;
        end

        S_RUN: begin
          if (cnt == PL_LAST) begin
            Run   <= 1'b1;
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_WAIT: begin
          if (cnt == WC_LAST) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            if (ErrCount != 8'hFF) begin
              ErrCount <= ErrCount + 8'd1;
            end
            // Counts are cleared at Start, so zero means no earlier failure.
            if (ErrCount == 8'd0) begin
              FailA <= op_a;
              FailB <= op_b;
            end
          end
          VecCount <= vec_next;
          cnt      <= '0;
          if (vec_next == VEC_LAST) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            op_a  <= lfsr;
            SW    <= lfsr;
            lfsr  <= lfsr_next;
            LoadA <= 1'b0;
            state <= S_LDA;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_stim_sequencer.sv
// tb/tb_adder_stim_sequencer.sv - scoreboard bench for adder_stim_sequencer

module tb_adder_stim_sequencer;

  localparam int NV     = 16;
  localparam int PERIOD = 29;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] Sum;
  logic        CO;
  logic [15:0] SW;
  logic        LoadA, LoadB, Run, Busy, Done;
  logic [7:0]  VecCount, ErrCount;
  logic [15:0] FailA, FailB;

  adder_stim_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Sum(Sum), .CO(CO),
    .SW(SW), .LoadA(LoadA), .LoadB(LoadB), .Run(Run), .Busy(Busy),
    .Done(Done), .VecCount(VecCount), .ErrCount(ErrCount),
    .FailA(FailA), .FailB(FailB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural adder top level: registers capture SW on low load strobes,
  // the result is computed on the onset of Run.  Modes: 0 correct, 1 forced
  // zero, 2 carry inverted, 3 random single-bit corruption on random vectors.
  int          mode = 0;
  logic [15:0] ra = '0, rb = '0;
  logic [16:0] res = '0;
  logic [16:0] corr;
  logic        prev_run = 1'b1;
  int          inj_cnt = 0;
  bit          inj_seen = 0;
  logic [15:0] inj_a, inj_b;

  assign Sum = res[15:0];
  assign CO  = res[16];

  always @(posedge Clk) begin
    if (!LoadA) ra <= SW;
    if (!LoadB) rb <= SW;
    if (!Run && prev_run) begin
      corr = {1'b0, ra} + {1'b0, rb};
      case (mode)
        1: res <= '0;
        2: res <= corr ^ 17'h10000;
        3: begin
          if ($urandom_range(0, 1) == 1) begin
            res <= corr ^ (17'h1 << $urandom_range(0, 16));
            inj_cnt++;
            if (!inj_seen) begin
              inj_seen = 1;
              inj_a = ra;
              inj_b = rb;
            end
          end else begin
            res <= corr;
          end
        end
        default: res <= corr;
      endcase
    end
    prev_run <= Run;
  end

  // Reference model: operand stream from the LFSR rule, expected SW values
  // queued per strobe for the monitor.
  logic [15:0] mlfsr = 16'hACE1;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          exp_err;
  logic [15:0] exp_fa, exp_fb;

  function automatic logic [15:0] ref_step(input logic [15:0] x);
    int ones;
    ones = int'(x[0]) + int'(x[2]) + int'(x[3]) + int'(x[5]);
    return (16'(ones % 2) << 15) | (x >> 1);
  endfunction

  task automatic plan_run(input int m);
    logic [15:0] a, b;
    logic [16:0] good, got;
    exp_err = 0;
    exp_fa  = '0;
    exp_fb  = '0;
    for (int v = 0; v < NV; v++) begin
      a = mlfsr; mlfsr = ref_step(mlfsr);
      b = mlfsr; mlfsr = ref_step(mlfsr);
      exp_a.push_back(a);
      exp_b.push_back(b);
      good = 17'(a) + 17'(b);
      got  = (m == 1) ? 17'h0 : (m == 2) ? (good ^ 17'h10000) : good;
      if (got != good) begin
        if (exp_err == 0) begin
          exp_fa = a;
          exp_fb = b;
        end
        exp_err++;
      end
    end
  endtask

  // Monitor: pops expected operands at each load-strobe onset and checks SW
  // stability and strobe exclusivity on every low-strobe cycle.
  logic        prev_la = 1'b1, prev_lb = 1'b1;
  logic [15:0] held_a, held_b;
  int          vec_seen = 0;
  logic [15:0] first_a, first_b;

  always @(negedge Clk) begin
    if (Reset) begin
      if (!LoadA || !LoadB || !Run)
        chk("one_strobe_low", 32'(int'(!LoadA) + int'(!LoadB) + int'(!Run) <= 1), 32'd1);
      if (!LoadA && prev_la) begin
        held_a = SW;
        if (vec_seen == 0) first_a = SW;
        vec_seen++;
        if (exp_a.size() == 0) chk("loada_expected", 32'd0, 32'd1);
        else chk("sw_at_loada", 32'(SW), 32'(exp_a.pop_front()));
      end else if (!LoadA) begin
        chk("sw_stable_loada", 32'(SW), 32'(held_a));
      end
      if (!LoadB && prev_lb) begin
        held_b = SW;
        if (vec_seen == 1) first_b = SW;
        if (exp_b.size() == 0) chk("loadb_expected", 32'd0, 32'd1);
        else chk("sw_at_loadb", 32'(SW), 32'(exp_b.pop_front()));
      end else if (!LoadB) begin
        chk("sw_stable_loadb", 32'(SW), 32'(held_b));
      end
    end
    prev_la = Reset ? LoadA : 1'b1;
    prev_lb = Reset ? LoadB : 1'b1;
  end

  task automatic run_vec(input int m, input bit mid_start);
    int busy_cyc;
    int guard;
    mode     = m;
    inj_cnt  = 0;
    inj_seen = 0;
    vec_seen = 0;
    plan_run(m);
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
    chk("done_cleared", 32'(Done), 32'd0);
    busy_cyc = 1;
    guard    = 0;
    fork
      begin
        while (!Done && guard < NV * PERIOD + 100) begin
          @(negedge Clk);
          if (Busy) busy_cyc++;
          guard++;
        end
      end
      begin
        if (mid_start) begin
          repeat ($urandom_range(20, 400)) @(negedge Clk);
          Start = 1'b1;
          @(negedge Clk);
          Start = 1'b0;
        end
      end
    join
    chk("done_within_budget", 32'(Done), 32'd1);
    chk("run_length", 32'(busy_cyc), 32'(NV * PERIOD));
    chk("busy_end", 32'(Busy), 32'd0);
    chk("vec_count", 32'(VecCount), 32'(NV));
    if (m == 3) begin
      exp_err = inj_cnt;
      exp_fa  = inj_seen ? inj_a : 16'h0;
      exp_fb  = inj_seen ? inj_b : 16'h0;
    end
    chk("err_count", 32'(ErrCount), 32'(exp_err > 255 ? 255 : exp_err));
    chk("fail_a", 32'(FailA), 32'(exp_fa));
    chk("fail_b", 32'(FailB), 32'(exp_fb));
    chk("queues_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_loada"}, 32'(LoadA), 32'd1);
    chk({tag, "_loadb"}, 32'(LoadB), 32'd1);
    chk({tag, "_run"}, 32'(Run), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_veccount"}, 32'(VecCount), 32'd0);
    chk({tag, "_errcount"}, 32'(ErrCount), 32'd0);
    chk({tag, "_fail_ab"}, {FailA, FailB}, 32'd0);
    chk({tag, "_sw"}, 32'(SW), 32'd0);
  endtask

  initial begin
    int guard;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b1;
    @(negedge Clk);
    check_idle_outputs("after_reset");

    run_vec(0, 1'b0);
    chk("first_a_seed", 32'(first_a), 32'h0000ACE1);
    chk("first_b_seed", 32'(first_b), 32'h00005670);

    run_vec(1, 1'b1);
    chk("second_run_a_not_seed", 32'(first_a != 16'hACE1), 32'd1);
    run_vec(2, 1'b1);
    run_vec(3, 1'b0);

    // Abort during WAIT of vector 5.
    mode     = 0;
    vec_seen = 0;
    plan_run(0);
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    guard = 0;
    while (VecCount != 8'd4 && guard < 1000) begin @(negedge Clk); guard++; end
    while (Run && guard < 1000) begin @(negedge Clk); guard++; end
    while (!Run && guard < 1000) begin @(negedge Clk); guard++; end
    chk("reached_vector5_wait", 32'(guard < 1000), 32'd1);
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_idle_outputs("mid_run_reset");
    exp_a.delete();
    exp_b.delete();
    mlfsr = 16'hACE1;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    run_vec(0, 1'b0);
    chk("first_a_after_reset", 32'(first_a), 32'h0000ACE1);
    chk("first_b_after_reset", 32'(first_b), 32'h00005670);
    run_vec(3, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
